// File: rtl/timer_clk_prescaler_if.sv
// Purpose : Signal bundle between the TCR/timer-counter side and the count-enable
//           prescaler.
// Modports: master - drives en/cks (and ext_clk/ext_sel), observes the prescaler outputs
//           slave  - the prescaler itself
// Optional: TIMER_PSC_EXT_CLK_EN adds the external count clock and its select.
interface timer_clk_prescaler_if #(
  parameter int unsigned DIV_WIDTH = 4
);
  logic                 en;          // TCR enable bit
  logic [1:0]           cks;         // TCR clock select
`ifdef TIMER_PSC_EXT_CLK_EN
  logic                 ext_clk;     // external count clock, asynchronous to pclk
  logic                 ext_sel;     // 1 = count external edges
`endif
  logic                 clk_cnt_en;  // one-pclk count-enable tick
  logic [DIV_WIDTH-1:0] psc_cnt;     // prescaler count readback
  logic [1:0]           sel_active;  // divide select currently in effect

  modport master (
`ifdef TIMER_PSC_EXT_CLK_EN
    output ext_clk,
    output ext_sel,
`endif
    output en,
    output cks,
    input  clk_cnt_en,
    input  psc_cnt,
    input  sel_active
  );

  modport slave (
`ifdef TIMER_PSC_EXT_CLK_EN
    input  ext_clk,
    input  ext_sel,
`endif
    input  en,
    input  cks,
    output clk_cnt_en,
    output psc_cnt,
    output sel_active
  );
endinterface

// File: rtl/timer_clk_prescaler.sv
// Purpose : Count-enable prescaler for the 8-bit APB timer. Divides pclk by 2/4/8/16
//           and emits a registered one-pclk tick to the timer counter. Clock-select
//           changes take effect only at a period boundary.
// Ports   : pclk   - system clock, rising edge
//           preset - asynchronous active-high reset
//           bus    - timer_clk_prescaler_if.slave (en, cks, clk_cnt_en, psc_cnt,
//                    sel_active, plus ext_clk/ext_sel when enabled)
// Optional: define TIMER_PSC_EXT_CLK_EN to add the external count clock path and its
//           SYNC_STAGES parameter (the parameter only exists in that build).
module timer_clk_prescaler #(
  parameter int unsigned DIV_WIDTH = 4
`ifdef TIMER_PSC_EXT_CLK_EN
  , parameter int unsigned SYNC_STAGES = 2
`endif
) (
  input logic                  pclk,
  input logic                  preset,
  timer_clk_prescaler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] psc_cnt_q, psc_cnt_d;
  logic [1:0]           sel_active_q, sel_active_d;
  logic                 clk_cnt_en_q, clk_cnt_en_d;

  logic [DIV_WIDTH-1:0] term_cnt;
  logic                 terminal;
  logic                 sel_change;
  logic                 ext_mode;
  logic                 ext_toggle;
  logic                 ext_rise;

  // Terminal count is DIV-1 = 2^(sel+1)-1; computed wide so /16 does not overflow.
  assign term_cnt   = DIV_WIDTH'((32'd2 << sel_active_q) - 32'd1);
  assign terminal   = (psc_cnt_q == term_cnt);
  assign sel_change = (bus.cks != sel_active_q);

`ifdef TIMER_PSC_EXT_CLK_EN
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ext_prev_q;
  logic                   ext_sel_q;

  // Synchroniser chain, edge-detect flop and ext_sel history.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      sync_q     <= '0;
      ext_prev_q <= 1'b0;
      ext_sel_q  <= 1'b0;
    end else begin
      sync_q     <= (sync_q << 1) | SYNC_STAGES'(bus.ext_clk);
      ext_prev_q <= sync_q[SYNC_STAGES-1];
      ext_sel_q  <= bus.ext_sel;
    end
  end

  assign ext_rise   = sync_q[SYNC_STAGES-1] & ~ext_prev_q;
  assign ext_mode   = bus.ext_sel;
  assign ext_toggle = bus.ext_sel ^ ext_sel_q;
`else
  assign ext_rise   = 1'b0;
  assign ext_mode   = 1'b0;
  assign ext_toggle = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q      <= IDLE;
      psc_cnt_q    <= '0;
      sel_active_q <= 2'b00;
      clk_cnt_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      psc_cnt_q    <= psc_cnt_d;
      sel_active_q <= sel_active_d;
      clk_cnt_en_q <= clk_cnt_en_d;
    end
  end

  // Next state. A select change landing on a terminal edge is taken at once, so no PEND.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.en) state_d = RUN;
      RUN: begin
        if (!bus.en)                     state_d = IDLE;
        else if (sel_change && !terminal) state_d = PEND;
      end
      PEND: begin
        if (!bus.en)                     state_d = IDLE;
        else if (!sel_change || terminal) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    // External mode (or leaving it) restarts the internal phase and drops any pending select.
    if (ext_mode || ext_toggle) state_d = bus.en ? RUN : IDLE;
  end

  // Counter, tick and select updates.
  always_comb begin
    psc_cnt_d    = psc_cnt_q;
    sel_active_d = sel_active_q;
    clk_cnt_en_d = 1'b0;
    if (ext_mode || ext_toggle) begin
      psc_cnt_d    = '0;
      sel_active_d = bus.cks;
      clk_cnt_en_d = ext_mode && bus.en && ext_rise;
    end else if (state_q == IDLE) begin
      psc_cnt_d    = '0;
      sel_active_d = bus.cks;
    end else if (!bus.en) begin
      psc_cnt_d    = '0;
    end else if (terminal) begin
      // Tick with the old divide; any requested select starts its period from this edge.
      psc_cnt_d    = '0;
      clk_cnt_en_d = 1'b1;
      sel_active_d = bus.cks;
    end else begin
      psc_cnt_d    = psc_cnt_q + DIV_WIDTH'(1);
    end
  end

  assign bus.clk_cnt_en = clk_cnt_en_q;
  assign bus.psc_cnt    = psc_cnt_q;
  assign bus.sel_active = sel_active_q;

endmodule

// File: tb/tb_timer_clk_prescaler.sv
// Bench for timer_clk_prescaler: expected tick edges are queued as stimulus is applied
// and a monitor checks clk_cnt_en on every pclk edge against the head of the queue.
module tb_timer_clk_prescaler;

  logic pclk;
  logic preset;

  int n_vec = 0;
  int n_err = 0;
  int edge_n = 0;
  int tick_cnt = 0;
  int exp_q[$];

  timer_clk_prescaler_if #(.DIV_WIDTH(4)) bus ();

  timer_clk_prescaler #(.DIV_WIDTH(4)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Tick monitor: every edge, clk_cnt_en must be high exactly on queued edges.
  initial begin
    logic exp_tick;
    forever begin
      @(posedge pclk);
      edge_n++;
      #1;
      exp_tick = 1'b0;
      if (exp_q.size() != 0 && exp_q[0] == edge_n) begin
        exp_tick = 1'b1;
        void'(exp_q.pop_front());
      end
      if (bus.clk_cnt_en === 1'b1) tick_cnt++;
      n_vec++;
      assert (bus.clk_cnt_en === exp_tick) else begin
        n_err++;
        $error("FAIL tick@%0d: observed %0b expected %0b", edge_n, bus.clk_cnt_en, exp_tick);
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns at the falling edge after edge 'target' has been checked.
  task automatic wait_edge(input int target);
    while (edge_n < target) @(negedge pclk);
  endtask

  initial begin
    int e0;
    int t0;
    preset  = 1'b1;
    bus.en  = 1'b0;
    bus.cks = 2'b00;
`ifdef TIMER_PSC_EXT_CLK_EN
    bus.ext_clk = 1'b0;
    bus.ext_sel = 1'b0;
`endif
    #2;
    chk("rst_tick", int'(bus.clk_cnt_en), 0);
    chk("rst_psc", int'(bus.psc_cnt), 0);
    chk("rst_sel", int'(bus.sel_active), 0);
    #1 preset = 1'b0;
    @(negedge pclk);

    // IDLE follows cks every cycle and holds the count at 0.
    bus.cks = 2'b10;
    wait_edge(edge_n + 1);
    chk("idle_sel", int'(bus.sel_active), 2);
    chk("idle_psc", int'(bus.psc_cnt), 0);

    // /4 long run: ticks every 4 edges; tick counts over 1000 and 1024 edges.
    bus.cks = 2'b01;
    bus.en  = 1'b1;
    e0 = edge_n + 1;
    t0 = tick_cnt;
    for (int k = 1; 4 * k < 1028; k++) exp_q.push_back(e0 + 4 * k);
    wait_edge(e0);
    chk("t1_psc_e0", int'(bus.psc_cnt), 0);
    wait_edge(e0 + 3);
    chk("t1_psc_e3", int'(bus.psc_cnt), 3);
    wait_edge(e0 + 1000);
    chk("t1_ticks_1000", tick_cnt - t0, 250);
    wait_edge(e0 + 1024);
    chk("t1_ticks_1024", tick_cnt - t0, 256);
    wait_edge(e0 + 1027);
    bus.en = 1'b0;
    wait_edge(e0 + 1028);
    chk("t1_stop_psc", int'(bus.psc_cnt), 0);

    // /2 then a fresh enable at /16: count sequences and periods.
    bus.cks = 2'b00;
    bus.en  = 1'b1;
    e0 = edge_n + 1;
    for (int k = 1; 2 * k < 8; k++) exp_q.push_back(e0 + 2 * k);
    for (int j = 0; j < 6; j++) begin
      wait_edge(e0 + j);
      chk("t2_psc_div2", int'(bus.psc_cnt), j % 2);
    end
    wait_edge(e0 + 7);
    bus.en = 1'b0;
    wait_edge(e0 + 8);
    bus.cks = 2'b11;
    bus.en  = 1'b1;
    e0 = edge_n + 1;
    exp_q.push_back(e0 + 16);
    exp_q.push_back(e0 + 32);
    for (int j = 0; j < 20; j++) begin
      wait_edge(e0 + j);
      chk("t2_psc_div16", int'(bus.psc_cnt), j % 16);
    end
    chk("t2_sel", int'(bus.sel_active), 3);
    wait_edge(e0 + 47);
    bus.en = 1'b0;
    wait_edge(e0 + 48);

    // Select change mid-period is deferred to the next /4 boundary.
    bus.cks = 2'b01;
    bus.en  = 1'b1;
    e0 = edge_n + 1;
    exp_q.push_back(e0 + 4);
    exp_q.push_back(e0 + 8);
    exp_q.push_back(e0 + 24);
    exp_q.push_back(e0 + 40);
    wait_edge(e0 + 5);
    bus.cks = 2'b11;
    wait_edge(e0 + 7);
    chk("t3_sel_pending", int'(bus.sel_active), 1);
    chk("t3_psc_e7", int'(bus.psc_cnt), 3);
    wait_edge(e0 + 8);
    chk("t3_sel_taken", int'(bus.sel_active), 3);
    chk("t3_psc_e8", int'(bus.psc_cnt), 0);
    wait_edge(e0 + 47);
    bus.en = 1'b0;
    wait_edge(e0 + 48);

    // Pending change cancelled before the boundary.
    bus.cks = 2'b01;
    bus.en  = 1'b1;
    e0 = edge_n + 1;
    exp_q.push_back(e0 + 4);
    exp_q.push_back(e0 + 8);
    exp_q.push_back(e0 + 12);
    wait_edge(e0 + 1);
    bus.cks = 2'b11;
    wait_edge(e0 + 2);
    bus.cks = 2'b01;
    wait_edge(e0 + 4);
    chk("t3b_sel_cancel", int'(bus.sel_active), 1);
    wait_edge(e0 + 15);
    bus.en = 1'b0;
    wait_edge(e0 + 16);

    // Change sampled on the terminal edge: tick with /4, /16 starts from that edge.
    bus.cks = 2'b01;
    bus.en  = 1'b1;
    e0 = edge_n + 1;
    exp_q.push_back(e0 + 4);
    exp_q.push_back(e0 + 20);
    exp_q.push_back(e0 + 36);
    wait_edge(e0 + 3);
    bus.cks = 2'b11;
    wait_edge(e0 + 4);
    chk("t3c_sel", int'(bus.sel_active), 3);
    chk("t3c_psc_e4", int'(bus.psc_cnt), 0);
    wait_edge(e0 + 5);
    chk("t3c_psc_e5", int'(bus.psc_cnt), 1);
    wait_edge(e0 + 39);
    bus.en = 1'b0;
    wait_edge(e0 + 40);

    // Disable on the terminal edge suppresses the tick; re-enable restarts the phase.
    bus.cks = 2'b01;
    bus.en  = 1'b1;
    e0 = edge_n + 1;
    wait_edge(e0 + 3);
    bus.en = 1'b0;
    wait_edge(e0 + 4);
    chk("t4_psc_drop", int'(bus.psc_cnt), 0);
    wait_edge(e0 + 9);
    bus.en = 1'b1;
    exp_q.push_back(e0 + 14);
    wait_edge(e0 + 12);
    chk("t4_psc_e12", int'(bus.psc_cnt), 2);
    wait_edge(e0 + 15);
    bus.en = 1'b0;
    wait_edge(e0 + 16);

    // Asynchronous reset mid-period, checked between clock edges.
    bus.cks = 2'b11;
    bus.en  = 1'b1;
    e0 = edge_n + 1;
    wait_edge(e0 + 2);
    chk("t5_psc_pre", int'(bus.psc_cnt), 2);
    chk("t5_sel_pre", int'(bus.sel_active), 3);
    #2 preset = 1'b1;
    #1;
    chk("t5_rst_tick", int'(bus.clk_cnt_en), 0);
    chk("t5_rst_psc", int'(bus.psc_cnt), 0);
    chk("t5_rst_sel", int'(bus.sel_active), 0);
    bus.en = 1'b0;
    #1 preset = 1'b0;
    wait_edge(edge_n + 2);
    chk("t5_idle_psc", int'(bus.psc_cnt), 0);

`ifdef TIMER_PSC_EXT_CLK_EN
    // External clock, 10 pclk period: tick 3 edges after each sampled rise.
    bus.cks     = 2'b00;
    bus.en      = 1'b1;
    bus.ext_sel = 1'b1;
    e0 = edge_n + 1;
    for (int r = 0; r < 4; r++) begin
      wait_edge(e0 + 4 + 10 * r);
      bus.ext_clk = 1'b1;
      exp_q.push_back(e0 + 7 + 10 * r);
      wait_edge(e0 + 9 + 10 * r);
      bus.ext_clk = 1'b0;
      chk("t6_psc_hold", int'(bus.psc_cnt), 0);
    end
    wait_edge(e0 + 45);
    bus.en      = 1'b0;
    bus.ext_sel = 1'b0;
    wait_edge(e0 + 46);
`endif

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
